// File: rtl/fpu_norm_pipe_if.sv
// rtl/fpu_norm_pipe_if.sv - operand/result handshake bundle for fpu_norm_pipe
//
// Purpose: groups the upstream operand stream and the downstream result
// stream of the normaliser pipeline.
// Ports (signals):
//   Valid_SI/Ready_SO                          operand handshake
//   Mant_in_DI, Exp_in_DI, Sign_in_DI, RM_SI   operand payload
//   Valid_SO/Ready_SI                          result handshake
//   Sign_res_DO, Exp_res_DO, Mant_res_DO       packed result
//   NX_SO, OF_SO, UF_SO                        exception flags
// Modports: master = producer of operands / consumer of results,
//           slave  = the normaliser pipeline itself.
interface fpu_norm_pipe_if #(
    parameter int C_EXP          = 8,
    parameter int C_MANT         = 23,
    parameter int C_MANT_PRENORM = 48,
    parameter int C_EXP_PRENORM  = C_EXP + 2
);
    logic                      Valid_SI;
    logic                      Ready_SO;
    logic [C_MANT_PRENORM-1:0] Mant_in_DI;
    logic [C_EXP_PRENORM-1:0]  Exp_in_DI;
    logic                      Sign_in_DI;
    logic [2:0]                RM_SI;
    logic                      Valid_SO;
    logic                      Ready_SI;
    logic                      Sign_res_DO;
    logic [C_EXP-1:0]          Exp_res_DO;
    logic [C_MANT:0]           Mant_res_DO;
    logic                      NX_SO;
    logic                      OF_SO;
    logic                      UF_SO;

    modport master (
        output Valid_SI, Mant_in_DI, Exp_in_DI, Sign_in_DI, RM_SI, Ready_SI,
        input  Ready_SO, Valid_SO, Sign_res_DO, Exp_res_DO, Mant_res_DO,
               NX_SO, OF_SO, UF_SO
    );

    modport slave (
        input  Valid_SI, Mant_in_DI, Exp_in_DI, Sign_in_DI, RM_SI, Ready_SI,
        output Ready_SO, Valid_SO, Sign_res_DO, Exp_res_DO, Mant_res_DO,
               NX_SO, OF_SO, UF_SO
    );
endinterface

// File: rtl/fpu_norm_pipe.sv
// rtl/fpu_norm_pipe.sv - two-stage floating-point normaliser/rounder with valid/ready flow control
//
// Purpose: normalises an unnormalised sign/exponent/mantissa (two integer
// bits, binary point below bit C_MANT_PRENORM-2), rounds it in one of five
// modes and packs an IEEE-754 style result with NX/OF/UF flags.
// Stage 1 does leading-one detection and the alignment shift; stage 2 does
// the rounding increment, overflow saturation and drives the outputs.
// Ports:
//   Clk_CI    clock
//   Rst_RI    synchronous active-high reset (wins over flush)
//   Flush_SI  drops every in-flight operation and the input of that cycle
//   bus       fpu_norm_pipe_if.slave operand/result streams
module fpu_norm_pipe #(
    parameter int C_EXP          = 8,
    parameter int C_MANT         = 23,
    parameter int C_MANT_PRENORM = 48,
    parameter int C_EXP_PRENORM  = C_EXP + 2
) (
    input  logic           Clk_CI,
    input  logic           Rst_RI,
    input  logic           Flush_SI,
    fpu_norm_pipe_if.slave bus
);
    localparam int W   = C_MANT_PRENORM;
    localparam int M   = C_MANT;
    localparam int EP  = C_EXP_PRENORM;
    localparam int K   = M + 3;               // mantissa + guard + round
    localparam int LZW = $clog2(W);
    localparam int EW  = EP + LZW + 2;        // headroom for exponent adjust
    localparam int SHW = $clog2(K);
    localparam logic [EP:0] EXP_INF = (EP + 1)'((1 << C_EXP) - 1);

    // ---------------- Stage 1: leading-one detect and alignment ----------------
    logic [LZW-1:0] w_lead_pos;
    always_comb begin
        w_lead_pos = '0;
        for (int i = 0; i < W; i++) begin
            if (bus.Mant_in_DI[i]) w_lead_pos = LZW'(i);
        end
    end

    logic           w_zero;
    logic [LZW-1:0] w_shl;
    logic [W-1:0]   w_norm;
    assign w_zero = ~|bus.Mant_in_DI;
    assign w_shl  = LZW'(W - 1) - w_lead_pos;
    // Lossless: the leading one ends up at bit W-1, which is the hidden bit.
    assign w_norm = bus.Mant_in_DI << w_shl;

    // A leading one at bit W-2 means 1.f, so the exponent moves by (pos - (W-2)).
    logic [EW-1:0] w_exp_in_ext;
    logic [EW-1:0] w_lead_ext;
    logic [EW-1:0] w_e_wide;
    assign w_exp_in_ext = {{(EW - EP){bus.Exp_in_DI[EP-1]}}, bus.Exp_in_DI};
    assign w_lead_ext   = {{(EW - LZW){1'b0}}, w_lead_pos};
    assign w_e_wide     = w_exp_in_ext + w_lead_ext - EW'(W - 2);

    logic          w_denorm;
    logic [EW-1:0] w_sh_wide;
    logic          w_collapse;
    assign w_denorm   = w_e_wide[EW-1] | (w_e_wide == '0);
    assign w_sh_wide  = EW'(1) - w_e_wide;
    assign w_collapse = (w_sh_wide >= EW'(K));

    logic [K-1:0] w_kept;
    logic         w_st_low;
    assign w_kept = w_norm[W-1 -: K];
    generate
        if (W > K) begin : g_st_low
            assign w_st_low = |w_norm[W-K-1:0];
        end else begin : g_no_st_low
            assign w_st_low = 1'b0;
        end
    endgenerate

    // Denormal path: shift the kept bits right, spilled bits feed sticky.
    logic [2*K-1:0] w_dn_ext;
    assign w_dn_ext = {w_kept, {K{1'b0}}} >> w_sh_wide[SHW-1:0];

    logic [K-1:0]  w_s1_kept;
    logic          w_s1_st;
    logic [EP-1:0] w_s1_e;
    always_comb begin
        w_s1_kept = w_kept;
        w_s1_st   = w_st_low;
        w_s1_e    = w_e_wide[EP-1:0];
        if (w_zero) begin
            w_s1_kept = '0;
            w_s1_st   = 1'b0;
            w_s1_e    = '0;
        end else if (w_denorm) begin
            w_s1_e = '0;
            if (w_collapse) begin
                w_s1_kept = '0;
                w_s1_st   = (|w_kept) | w_st_low;
            end else begin
                w_s1_kept = w_dn_ext[2*K-1:K];
                w_s1_st   = (|w_dn_ext[K-1:0]) | w_st_low;
            end
        end
    end

    // ---------------- Flow control ----------------
    logic r_v1;
    logic r_v2;
    logic w_s2_load;
    logic w_s1_load;
    assign w_s2_load    = ~r_v2 | bus.Ready_SI;
    assign w_s1_load    = ~r_v1 | w_s2_load;
    // During a flush the offered input is swallowed, so the port stays ready.
    assign bus.Ready_SO = w_s1_load | Flush_SI;

    // ---------------- S1 registers ----------------
    logic          r_sign1;
    logic [2:0]    r_rm1;
    logic [EP-1:0] r_e1;
    logic [M:0]    r_m1;
    logic          r_g1;
    logic          r_r1;
    logic          r_s1;
    logic          r_den1;
    logic          r_zero1;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_sign1 <= 1'b0;
            r_rm1   <= '0;
            r_e1    <= '0;
            r_m1    <= '0;
            r_g1    <= 1'b0;
            r_r1    <= 1'b0;
            r_s1    <= 1'b0;
            r_den1  <= 1'b0;
            r_zero1 <= 1'b0;
        end else if (w_s1_load && bus.Valid_SI) begin
            r_sign1 <= bus.Sign_in_DI;
            r_rm1   <= bus.RM_SI;
            r_e1    <= w_s1_e;
            r_m1    <= w_s1_kept[K-1:2];
            r_g1    <= w_s1_kept[1];
            r_r1    <= w_s1_kept[0];
            r_s1    <= w_s1_st;
            r_den1  <= w_denorm & ~w_zero;
            r_zero1 <= w_zero;
        end
    end

    // ---------------- Stage 2: rounding and overflow ----------------
    logic w_grs;
    logic w_rnd_up;
    logic w_ovf_inf;
    assign w_grs = r_g1 | r_r1 | r_s1;

    // w_ovf_inf: overflow goes to infinity (rounding away from zero) vs max finite.
    always_comb begin
        w_rnd_up  = r_g1 & (r_r1 | r_s1 | r_m1[0]);
        w_ovf_inf = 1'b1;
        case (r_rm1)
            3'b001: begin
                w_rnd_up  = 1'b0;
                w_ovf_inf = 1'b0;
            end
            3'b010: begin
                w_rnd_up  = w_grs & r_sign1;
                w_ovf_inf = r_sign1;
            end
            3'b011: begin
                w_rnd_up  = w_grs & ~r_sign1;
                w_ovf_inf = ~r_sign1;
            end
            3'b100: begin
                w_rnd_up  = r_g1;
                w_ovf_inf = 1'b1;
            end
            default: begin
                w_rnd_up  = r_g1 & (r_r1 | r_s1 | r_m1[0]);
                w_ovf_inf = 1'b1;
            end
        endcase
    end

    logic [M+1:0] w_sum;
    logic [M:0]   w_m_rnd;
    logic [EP:0]  w_e_rnd;
    logic         w_ovf;
    assign w_sum   = {1'b0, r_m1} + {{(M + 1){1'b0}}, w_rnd_up};
    assign w_m_rnd = w_sum[M+1] ? w_sum[M+1:1] : w_sum[M:0];
    // Carry-out bumps a normal exponent; a denormal reaching the hidden bit becomes exponent 1.
    assign w_e_rnd = {1'b0, r_e1}
                   + {{EP{1'b0}}, w_sum[M+1] | ((r_e1 == '0) & w_sum[M])};
    assign w_ovf   = (w_e_rnd >= EXP_INF);

    logic [C_EXP-1:0] w_exp_nxt;
    logic [M:0]       w_mant_nxt;
    always_comb begin
        w_exp_nxt  = w_e_rnd[C_EXP-1:0];
        w_mant_nxt = w_m_rnd;
        if (w_ovf) begin
            if (w_ovf_inf) begin
                w_exp_nxt  = '1;
                w_mant_nxt = '0;
            end else begin
                w_exp_nxt  = {{(C_EXP - 1){1'b1}}, 1'b0};
                w_mant_nxt = '1;
            end
        end
    end

    logic w_nx_nxt;
    assign w_nx_nxt = (w_grs | w_ovf) & ~r_zero1;

    // ---------------- S2 registers (drive the outputs) ----------------
    logic             r_sign2;
    logic [C_EXP-1:0] r_exp2;
    logic [M:0]       r_mant2;
    logic             r_nx2;
    logic             r_of2;
    logic             r_uf2;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI || Flush_SI) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_exp2  <= '0;
            r_mant2 <= '0;
            r_nx2   <= 1'b0;
            r_of2   <= 1'b0;
            r_uf2   <= 1'b0;
        end else begin
            if (w_s1_load) r_v1 <= bus.Valid_SI;
            if (w_s2_load) r_v2 <= r_v1;
            if (w_s2_load && r_v1) begin
                r_sign2 <= r_sign1;
                r_exp2  <= w_exp_nxt;
                r_mant2 <= w_mant_nxt;
                r_nx2   <= w_nx_nxt;
                r_of2   <= w_ovf & ~r_zero1;
                r_uf2   <= r_den1 & w_nx_nxt;
            end
        end
    end

    assign bus.Valid_SO    = r_v2;
    assign bus.Sign_res_DO = r_sign2;
    assign bus.Exp_res_DO  = r_exp2;
    assign bus.Mant_res_DO = r_mant2;
    assign bus.NX_SO       = r_nx2;
    assign bus.OF_SO       = r_of2;
    assign bus.UF_SO       = r_uf2;
endmodule

// File: tb/tb_fpu_norm_pipe.sv
// tb/tb_fpu_norm_pipe.sv - directed scoreboard bench for fpu_norm_pipe
module tb_fpu_norm_pipe;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic [2:0]  f;   // {NX, OF, UF}
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    fpu_norm_pipe_if #(.C_EXP(8), .C_MANT(23), .C_MANT_PRENORM(48), .C_EXP_PRENORM(10)) bus ();

    fpu_norm_pipe #(.C_EXP(8), .C_MANT(23), .C_MANT_PRENORM(48), .C_EXP_PRENORM(10)) dut (
        .Clk_CI   (clk),
        .Rst_RI   (rst),
        .Flush_SI (flush),
        .bus      (bus)
    );

    res_t q[$];
    res_t cur;
    res_t held;
    logic hold_v = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        res_t obs;
        res_t want;
        obs = {bus.Sign_res_DO, bus.Exp_res_DO, bus.Mant_res_DO, bus.NX_SO, bus.OF_SO, bus.UF_SO};
        if (hold_v && bus.Valid_SO) begin
            checks++;
            assert (obs === held) else begin
                errors++;
                $error("FAIL stall_stable obs=%h exp=%h", obs, held);
            end
        end
        hold_v = bus.Valid_SO && !bus.Ready_SI && !rst && !flush;
        held   = obs;
        if (bus.Valid_SO && bus.Ready_SI && !rst && !flush) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output obs=%h exp=none", obs);
            end
            if (q.size() > 0) begin
                want = q.pop_front();
                checks++;
                assert (obs === want) else begin
                    errors++;
                    $error("FAIL result obs=%h exp=%h", obs, want);
                end
            end
        end
        if (rst || flush) q.delete();
        else if (bus.Valid_SI && bus.Ready_SO) q.push_back(cur);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] m, input logic [9:0] e, input logic s, input logic [2:0] rm,
                        input logic [7:0] xe, input logic [23:0] xm, input logic [2:0] xf);
        logic ok;
        ok = 1'b0;
        bus.Mant_in_DI = m;
        bus.Exp_in_DI  = e;
        bus.Sign_in_DI = s;
        bus.RM_SI      = rm;
        cur            = {s, xe, xm, xf};
        bus.Valid_SI   = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.Ready_SO;
            tick();
        end
        bus.Valid_SI = 1'b0;
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout obs=%b exp=1", ok);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain obs=%0d exp=0", q.size());
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        logic [35:0] outs;
        outs = {bus.Sign_res_DO, bus.Exp_res_DO, bus.Mant_res_DO, bus.NX_SO, bus.OF_SO, bus.UF_SO};
        check_bit({tag, "_valid"}, bus.Valid_SO, 1'b0);
        check_bit({tag, "_ready"}, bus.Ready_SO, 1'b1);
        checks++;
        assert (outs === 36'h0) else begin
            errors++;
            $error("FAIL %s_outputs obs=%h exp=0", tag, outs);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.Valid_SI = 1'b0;
        bus.Ready_SI = 1'b1;
        bus.Mant_in_DI = '0;
        bus.Exp_in_DI = '0;
        bus.Sign_in_DI = 1'b0;
        bus.RM_SI = RNE;
        cur = '0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // Basic normal value and two-cycle latency
        send(48'h4000_0000_0000, 10'd127, 1'b0, RNE, 8'h7F, 24'h800000, 3'b000);
        check_bit("latency_s1", bus.Valid_SO, 1'b0);
        tick();
        check_bit("latency_s2", bus.Valid_SO, 1'b1);
        drain();

        // Exact tie in every rounding mode, plus an unused RM code
        send(48'h4000_0040_0000, 10'd127, 1'b0, RNE, 8'h7F, 24'h800000, 3'b100);
        send(48'h4000_0040_0000, 10'd127, 1'b0, RMM, 8'h7F, 24'h800001, 3'b100);
        send(48'h4000_0040_0000, 10'd127, 1'b1, RUP, 8'h7F, 24'h800000, 3'b100);
        send(48'h4000_0040_0000, 10'd127, 1'b0, RUP, 8'h7F, 24'h800001, 3'b100);
        send(48'h4000_0040_0000, 10'd127, 1'b1, RDN, 8'h7F, 24'h800001, 3'b100);
        send(48'h4000_0040_0000, 10'd127, 1'b0, RTZ, 8'h7F, 24'h800000, 3'b100);
        send(48'h4000_00C0_0000, 10'd127, 1'b0, 3'd7, 8'h7F, 24'h800002, 3'b100);
        drain();

        // Overflow saturation
        send(48'h4000_0000_0000, 10'd255, 1'b0, RNE, 8'hFF, 24'h000000, 3'b110);
        send(48'h4000_0000_0000, 10'd255, 1'b0, RTZ, 8'hFE, 24'hFFFFFF, 3'b110);
        send(48'h4000_0000_0000, 10'd255, 1'b0, RDN, 8'hFE, 24'hFFFFFF, 3'b110);
        send(48'h4000_0000_0000, 10'd255, 1'b1, RDN, 8'hFF, 24'h000000, 3'b110);
        send(48'h4000_0000_0000, 10'd255, 1'b1, RUP, 8'hFE, 24'hFFFFFF, 3'b110);
        // Rounding carry-out into the exponent, and carry into overflow
        send(48'h7FFF_FFC0_0001, 10'd127, 1'b0, RNE, 8'h80, 24'h800000, 3'b100);
        send(48'h7FFF_FFC0_0001, 10'd254, 1'b0, RNE, 8'hFF, 24'h000000, 3'b110);
        drain();

        // Denormals
        send(48'h4000_0000_0000, 10'h3FF, 1'b0, RNE, 8'h00, 24'h200000, 3'b000);
        send(48'h4000_0000_0001, 10'h3FF, 1'b0, RUP, 8'h00, 24'h200001, 3'b101);
        send(48'h7FFF_FFC0_0000, 10'd0,   1'b0, RNE, 8'h01, 24'h800000, 3'b101);
        // Zero keeps its sign and raises nothing
        send(48'h0, 10'd100, 1'b1, RUP, 8'h00, 24'h000000, 3'b000);
        drain();

        // Back-pressure: two accepts fill the pipe, then accept and emit together
        bus.Ready_SI = 1'b0;
        send(48'h4000_0000_0000, 10'd127, 1'b0, RNE, 8'h7F, 24'h800000, 3'b000);
        send(48'h4000_0040_0000, 10'd127, 1'b1, RMM, 8'h7F, 24'h800001, 3'b100);
        check_bit("full_ready", bus.Ready_SO, 1'b0);
        tick();
        check_bit("stall_ready", bus.Ready_SO, 1'b0);
        check_bit("stall_valid", bus.Valid_SO, 1'b1);
        bus.Ready_SI = 1'b1;
        #1;
        check_bit("release_ready", bus.Ready_SO, 1'b1);
        send(48'h4000_0000_0000, 10'd255, 1'b0, RTZ, 8'hFE, 24'hFFFFFF, 3'b110);
        send(48'h4000_0000_0000, 10'h3FF, 1'b1, RNE, 8'h00, 24'h200000, 3'b000);
        drain();

        // Reset with two operations in flight
        bus.Ready_SI = 1'b0;
        send(48'h4000_0000_0000, 10'd127, 1'b0, RNE, 8'h7F, 24'h800000, 3'b000);
        send(48'h4000_0000_0000, 10'd128, 1'b0, RNE, 8'h80, 24'h800000, 3'b000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_reset");
        bus.Ready_SI = 1'b1;
        repeat (5) tick();
        drain();

        // Flush with two in flight; the input offered in the flush cycle is dropped
        bus.Ready_SI = 1'b0;
        send(48'h4000_0000_0000, 10'd127, 1'b0, RNE, 8'h7F, 24'h800000, 3'b000);
        send(48'h4000_0000_0000, 10'd128, 1'b1, RNE, 8'h80, 24'h800000, 3'b000);
        flush = 1'b1;
        bus.Mant_in_DI = 48'h4000_0000_0000;
        bus.Exp_in_DI = 10'd129;
        bus.Valid_SI = 1'b1;
        #1;
        check_bit("flush_ready", bus.Ready_SO, 1'b1);
        tick();
        flush = 1'b0;
        bus.Valid_SI = 1'b0;
        check_idle("flush");
        bus.Ready_SI = 1'b1;
        repeat (5) tick();
        drain();

        // Pipeline still works after the flush
        send(48'h4000_0040_0000, 10'd127, 1'b0, RMM, 8'h7F, 24'h800001, 3'b100);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
